// File: rtl/cic_pkg.sv
// cic_pkg: constants and width helpers shared by the TX CIC interpolator and
// the RX CIC decimator.
//   CIC_DEF_STAGES   default number of comb/integrator stages (N)
//   CIC_DEF_RATIO    default rate-change factor (R)
//   CIC_DEF_IN_WIDTH default signed sample width
//   cic_clog2()      ceil(log2(value)), 0 for value <= 1
//   cic_acc_width()  in_width + ceil(stages*log2(ratio)), the CIC register growth
package cic_pkg;

  localparam int CIC_DEF_STAGES   = 3;
  localparam int CIC_DEF_RATIO    = 10;
  localparam int CIC_DEF_IN_WIDTH = 16;

  function automatic int cic_clog2(input longint value);
    int r;
    r = 0;
    for (int i = 0; i < 62; i++) begin
      if ((longint'(1) << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // ceil(stages*log2(ratio)) is computed as ceil(log2(ratio**stages)), which is
  // exact in integer arithmetic.
  function automatic int cic_acc_width(input int in_width, input int stages, input int ratio);
    longint gain;
    gain = 1;
    for (int i = 0; i < stages; i++) gain = gain * longint'(ratio);
    return in_width + cic_clog2(gain);
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// cic_integrator: one CIC integrator stage, acc <= acc + din on each strobe.
// Two's-complement wrap is intentional; the CIC recovers from it exactly.
//   clock     single clock
//   reset     synchronous, active-high; clears the accumulator
//   strobe_i  update enable (the high-rate tick)
//   din_i     stage input
//   acc_o     registered accumulator
module cic_integrator #(
  parameter int WIDTH = 26
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    strobe_i,
  input  logic signed [WIDTH-1:0] din_i,
  output logic signed [WIDTH-1:0] acc_o
);

  logic signed [WIDTH-1:0] acc_q;
  logic signed [WIDTH-1:0] acc_d;

  assign acc_d = acc_q + din_i;
  assign acc_o = acc_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
    end else if (strobe_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/cic_interp_comb.sv
// cic_interp_comb: one CIC comb stage for the interpolator, y = x - x_delayed.
// The difference is combinational so the whole comb chain settles in the same
// cycle as the consume tick; only the delay register is clocked.
//   clock   single clock
//   reset   synchronous, active-high; clears the delay
//   en_i    consume tick (low-rate update)
//   x_i     stage input
//   y_o     stage output (combinational)
module cic_interp_comb #(
  parameter int WIDTH = 26
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic signed [WIDTH-1:0] x_i,
  output logic signed [WIDTH-1:0] y_o
);

  logic signed [WIDTH-1:0] dly_q;

  assign y_o = x_i - dly_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      dly_q <= '0;
    end else if (en_i) begin
      dly_q <= x_i;
    end
  end

endmodule

// File: rtl/cic_interpolator.sv
// cic_interpolator: N-stage CIC interpolator, raises low-rate samples by
// INTERPOLATION. Samples enter through a one-deep hold register (valid/ready);
// the high-rate side paces the block with out_tick and gets one registered
// sample back one cycle after each tick.
//   clock      single clock
//   reset      synchronous, active-high
//   in_valid   in_data valid
//   in_ready   hold register can take a sample this cycle
//   in_data    signed low-rate sample
//   out_tick   high-rate strobe
//   out_valid  pulse, one cycle after each out_tick
//   out_data   shifted/saturated output, held between pulses
//   underflow  pulse: a consume tick found the hold register empty
// Build option: define CIC_ROUND_EN to round half up before the output shift
// (default is floor truncation).
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int STAGES        = CIC_DEF_STAGES,
  parameter int INTERPOLATION = CIC_DEF_RATIO,
  parameter int IN_WIDTH      = CIC_DEF_IN_WIDTH,
  parameter int ACC_WIDTH     = cic_acc_width(IN_WIDTH, STAGES, INTERPOLATION),
  parameter int OUT_WIDTH     = 16,
  parameter int OUT_SHIFT     = 7
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic                        out_tick,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        underflow
);

  localparam int PHASE_W = cic_clog2(longint'(INTERPOLATION));
  localparam int EXT_W   = ACC_WIDTH + 1;

  localparam longint                  SAT_MAX_L = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX   = EXT_W'(SAT_MAX_L);
  localparam logic signed [EXT_W-1:0] SAT_MIN   = EXT_W'(-SAT_MAX_L - 1);

  logic [PHASE_W-1:0]          phase_q, phase_d;
  logic signed [IN_WIDTH-1:0]  hold_q;
  logic                        hold_full_q;
  logic                        rdy_en_q;
  logic                        out_valid_q;
  logic                        underflow_q;
  logic signed [OUT_WIDTH-1:0] out_data_q;

  logic                        consume;
  logic                        transfer;
  logic signed [ACC_WIDTH-1:0] comb_in;
  logic signed [ACC_WIDTH-1:0] comb_out;
  logic signed [ACC_WIDTH-1:0] integ_in;
  logic signed [ACC_WIDTH-1:0] last_next;
  logic signed [EXT_W-1:0]     pre_shift;
  logic signed [EXT_W-1:0]     shifted;
  logic signed [OUT_WIDTH-1:0] sat_val;

  assign consume = out_tick && (phase_q == '0);

  // The held sample leaves on a consume tick, so the slot is offered to the
  // upstream in that same cycle; this keeps a back-to-back stream free of
  // underflows. rdy_en_q keeps in_ready low for the first cycle after reset.
  assign in_ready = rdy_en_q && (!hold_full_q || consume);
  assign transfer = in_valid && in_ready;

  assign phase_d = (phase_q == PHASE_W'(INTERPOLATION - 1)) ? '0 : phase_q + 1'b1;

  assign comb_in  = (consume && hold_full_q) ? ACC_WIDTH'(hold_q) : '0;
  assign integ_in = consume ? comb_out : '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_comb
    logic signed [ACC_WIDTH-1:0] x;
    logic signed [ACC_WIDTH-1:0] y;
    if (k == 0) begin : g_first
      assign x = comb_in;
    end else begin : g_next
      assign x = g_comb[k-1].y;
    end
    cic_interp_comb #(.WIDTH(ACC_WIDTH)) u_comb (
      .clock (clock),
      .reset (reset),
      .en_i  (consume),
      .x_i   (x),
      .y_o   (y)
    );
  end
  assign comb_out = g_comb[STAGES-1].y;

  for (genvar k = 0; k < STAGES; k++) begin : g_int
    logic signed [ACC_WIDTH-1:0] din;
    logic signed [ACC_WIDTH-1:0] acc;
    if (k == 0) begin : g_first
      assign din = integ_in;
    end else begin : g_next
      assign din = g_int[k-1].acc;
    end
    cic_integrator #(.WIDTH(ACC_WIDTH)) u_int (
      .clock    (clock),
      .reset    (reset),
      .strobe_i (out_tick),
      .din_i    (din),
      .acc_o    (acc)
    );
  end

  // The output register samples the value I_N takes on this tick, so a sample
  // consumed at tick t reaches out_data on tick t+STAGES-1.
  assign last_next = g_int[STAGES-1].acc + g_int[STAGES-1].din;

  // One guard bit keeps the rounding add from wrapping near full scale.
`ifdef CIC_ROUND_EN
  localparam logic signed [EXT_W-1:0] ROUND_ADD = EXT_W'((longint'(1) <<< OUT_SHIFT) >>> 1);
  assign pre_shift = EXT_W'(last_next) + ROUND_ADD;
`else
  assign pre_shift = EXT_W'(last_next);
`endif

  assign shifted = pre_shift >>> OUT_SHIFT;

  always_comb begin
    sat_val = OUT_WIDTH'(shifted);
    if (shifted > SAT_MAX) begin
      sat_val = OUT_WIDTH'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      sat_val = OUT_WIDTH'(SAT_MIN);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rdy_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      underflow_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      rdy_en_q    <= 1'b1;
      out_valid_q <= out_tick;
      underflow_q <= consume && !hold_full_q;
      if (out_tick) begin
        phase_q    <= phase_d;
        out_data_q <= sat_val;
      end
      if (transfer) begin
        hold_q      <= in_data;
        hold_full_q <= 1'b1;
      end else if (consume) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign underflow = underflow_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: three interpolators (OUT_SHIFT 7, 0 and 5) share one
// stimulus stream; outputs are compared each cycle against a convolution model
// built from the CIC impulse response (a length-R box filter raised to the
// N-th power) applied to the zero-stuffed consumed samples.
module tb_cic_interpolator;

  localparam int N    = 3;
  localparam int R    = 10;
  localparam int HLEN = N * (R - 1) + 1;
`ifdef CIC_ROUND_EN
  localparam int ROUND_EXP = 1;
`else
  localparam int ROUND_EXP = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic signed [15:0] in_data;
  logic out_tick;
  logic rdy0, rdy1, rdy2;
  logic ov0, ov1, ov2;
  logic uf0, uf1, uf2;
  logic signed [15:0] od0, od1, od2;

  always #5 clk = ~clk;

  cic_interpolator #(.STAGES(N), .INTERPOLATION(R), .IN_WIDTH(16), .ACC_WIDTH(26),
                     .OUT_WIDTH(16), .OUT_SHIFT(7)) u_dut (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .out_tick(out_tick), .out_valid(ov0), .out_data(od0), .underflow(uf0));

  cic_interpolator #(.STAGES(N), .INTERPOLATION(R), .IN_WIDTH(16), .ACC_WIDTH(26),
                     .OUT_WIDTH(16), .OUT_SHIFT(0)) u_dut_s0 (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_tick(out_tick), .out_valid(ov1), .out_data(od1), .underflow(uf1));

  cic_interpolator #(.STAGES(N), .INTERPOLATION(R), .IN_WIDTH(16), .ACC_WIDTH(26),
                     .OUT_WIDTH(16), .OUT_SHIFT(5)) u_dut_s5 (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .out_tick(out_tick), .out_valid(ov2), .out_data(od2), .underflow(uf2));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // reference model state
  int  h[HLEN];
  int  xs[$];
  int  shifts[3] = '{7, 0, 5};
  int  m_exp[3];
  int  m_phase;
  int  m_hold;
  bit  m_full;
  bit  m_rdy_en;
  bit  m_valid;
  bit  m_uf;

  function automatic int expect_out(input longint v, input int sh);
    longint q;
    q = v;
`ifdef CIC_ROUND_EN
    if (sh > 0) q = q + (longint'(1) <<< (sh - 1));
`endif
    q = q >>> sh;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  task automatic build_h();
    int t[HLEN];
    int len;
    for (int i = 0; i < HLEN; i++) h[i] = 0;
    h[0] = 1;
    len  = 1;
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < HLEN; i++) t[i] = 0;
      for (int i = 0; i < len; i++)
        for (int k = 0; k < R; k++) t[i + k] += h[i];
      h   = t;
      len = len + R - 1;
    end
  endtask

  task automatic check_outs(input string pfx);
    chk({pfx, "out_valid_s7"}, int'(ov0), int'(m_valid));
    chk({pfx, "out_valid_s0"}, int'(ov1), int'(m_valid));
    chk({pfx, "out_valid_s5"}, int'(ov2), int'(m_valid));
    chk({pfx, "out_data_s7"}, int'(od0), m_exp[0]);
    chk({pfx, "out_data_s0"}, int'(od1), m_exp[1]);
    chk({pfx, "out_data_s5"}, int'(od2), m_exp[2]);
    chk({pfx, "underflow"}, int'(uf0), int'(m_uf));
    chk({pfx, "underflow_s0"}, int'(uf1), int'(m_uf));
    chk({pfx, "underflow_s5"}, int'(uf2), int'(m_uf));
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    out_tick = 1'b0;
    @(posedge clk); #1;
    xs.delete();
    m_phase  = 0;
    m_hold   = 0;
    m_full   = 0;
    m_rdy_en = 0;
    m_valid  = 0;
    m_uf     = 0;
    for (int k = 0; k < 3; k++) m_exp[k] = 0;
    check_outs("rst_");
    chk("rst_in_ready", int'(rdy0), 0);
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, check in_ready, advance the model, check outputs.
  task automatic step(input bit v, input int d, input bit tk);
    bit     consume;
    bit     ready;
    longint acc;
    int     m;
    int     j;
    in_valid = v;
    in_data  = 16'(d);
    out_tick = tk;
    #3;
    consume = tk && (m_phase == 0);
    ready   = m_rdy_en && (!m_full || consume);
    chk("in_ready", int'(rdy0), int'(ready));
    chk("in_ready_s0", int'(rdy1), int'(ready));
    chk("in_ready_s5", int'(rdy2), int'(ready));
    m_valid = tk;
    m_uf    = 0;
    if (tk) begin
      if (consume) begin
        xs.push_back(m_full ? m_hold : 0);
        m_uf = !m_full;
      end else begin
        xs.push_back(0);
      end
      m   = xs.size() - 1;
      acc = 0;
      for (int i = 0; i < HLEN; i++) begin
        j = m - (N - 1) - i;
        if (j >= 0) acc += longint'(h[i]) * longint'(xs[j]);
      end
      for (int k = 0; k < 3; k++) m_exp[k] = expect_out(acc, shifts[k]);
      m_phase = (m_phase + 1) % R;
    end
    if (v && ready) begin
      m_full = 1;
      m_hold = d;
    end else if (consume) begin
      m_full = 0;
    end
    m_rdy_en = 1;
    @(posedge clk); #1;
    check_outs("");
  endtask

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  int ufc, nz, peak, sum;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    out_tick = 1'b0;
    build_h();
    @(posedge clk); #1;
    do_reset();

    // random streaming, then reset in the middle of it
    for (int c = 0; c < 300; c++) step($urandom_range(3) != 0, rnd16(), $urandom_range(1) == 1);
    in_valid = 1'b1;
    out_tick = 1'b1;
    do_reset();
    step(0, 0, 0);
    step(1, 1234, 0);
    step(0, 0, 1);
    chk("restart_first_out", int'(od0), 0);
    chk("restart_first_valid", int'(ov0), 1);

    // DC: 1280 * R^(N-1) / 2^7 = 1000
    do_reset();
    step(0, 0, 0);
    for (int c = 0; c < 40 * R; c++) step(1, 1280, 1);
    chk("dc_out", int'(od0), 1000);

    // withhold in_valid across two consume ticks: the held sample covers the
    // first, the second underflows
    ufc = 0;
    for (int c = 0; c < 2 * R; c++) begin
      step(0, 0, 1);
      ufc += int'(uf0);
    end
    chk("withhold_underflow_count", ufc, 1);

    // hold is empty; load 777, then offer -555 while not ready
    step(1, 777, 0);
    step(1, -555, 0);
    chk("ignored_in_ready", int'(rdy0), 0);
    for (int g = 0; g < R && m_phase != 0; g++) step(0, 0, 1);
    step(1, 4321, 1);
    chk("consume_xfer_no_underflow", int'(uf0), 0);
    chk("consume_xfer_hold_full", int'(rdy0), 0);
    for (int c = 0; c < 4 * R; c++) step(0, 0, 1);

    // rounding: 1 * 100 / 128 = 0.78
    do_reset();
    step(0, 0, 0);
    for (int c = 0; c < 40 * R; c++) step(1, 1, 1);
    chk("round_out", int'(od0), ROUND_EXP);

    // saturation at OUT_SHIFT=5
    for (int c = 0; c < 40 * R; c++) step(1, 32767, 1);
    chk("sat_pos", int'(od2), 32767);
    for (int c = 0; c < 40 * R; c++) step(1, -32768, 1);
    chk("sat_neg", int'(od2), -32768);

    // impulse at OUT_SHIFT=0
    do_reset();
    step(0, 0, 0);
    step(1, 1, 0);
    nz   = 0;
    peak = 0;
    sum  = 0;
    for (int c = 0; c < 60; c++) begin
      step(1, 0, 1);
      if (ov1) begin
        if (od1 != 0) nz++;
        if (int'(od1) > peak) peak = int'(od1);
        sum += int'(od1);
      end
    end
    chk("impulse_nonzero", nz, HLEN);
    chk("impulse_peak", peak, 75);
    chk("impulse_sum", sum, 1000);

    // random traffic with gaps on both sides
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) do_reset();
      step($urandom_range(4) != 0, rnd16(), $urandom_range(2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
